// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: run/step/halt sequencing for the 5-stage pipeline,
// per-stage write/flush/bubble controls and saturating stall/flush statistics.
// Optional feature macro: STALL_WATCHDOG_EN -- halts with o_error after
// STALL_LIMIT consecutive enabled stall cycles.
module pipeline_stall_controller #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STALL_LIMIT = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic             i_halt_wb,
  input  logic             i_dbg_run,
  input  logic             i_dbg_step,
  input  logic             i_dbg_clear,
  output logic             o_pipe_enable,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_halted,
  output logic             o_step_done,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count,
  output logic             o_error
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             step_done_q, step_done_d;
  logic             stat_clear;
  logic             wd_trip;

  assign stat_clear = (state_q == S_HALTED) && i_dbg_clear;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: run beats step in IDLE; HALT in WB or a watchdog trip ends RUN/STEP
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_dbg_run) begin
          state_d = S_RUN;
        end else if (i_dbg_step) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        if (i_halt_wb || wd_trip) begin
          state_d = S_HALTED;
        end else if (!i_dbg_run) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (i_halt_wb || wd_trip) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALTED: begin
        if (i_dbg_clear) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage controls: stall wins over a taken branch since branch operands are stale
  always_comb begin
    o_pipe_enable = (state_q == S_RUN) || (state_q == S_STEP);
    o_halted      = (state_q == S_HALTED);
    o_pc_write    = 1'b0;
    o_ifid_write  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    if (o_pipe_enable) begin
      o_pc_write    = !i_stall;
      o_ifid_write  = !i_stall;
      o_idex_bubble = i_stall;
      o_ifid_flush  = i_branch_taken && !i_stall;
    end
  end

  // Statistics and step-done pulse next values
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    step_done_d = (state_q == S_STEP);
    if (stat_clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (o_idex_bubble && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (o_ifid_flush && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // Statistics and step-done registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      step_done_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      step_done_q <= step_done_d;
    end
  end

  assign o_stall_count = stall_cnt_q;
  assign o_flush_count = flush_cnt_q;
  assign o_step_done   = step_done_q;

`ifdef STALL_WATCHDOG_EN
  localparam int unsigned WD_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            error_q, error_d;

  // Consecutive enabled-stall streak; disabled cycles hold it
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    error_d  = error_q;
    wd_trip  = 1'b0;
    if (stat_clear) begin
      wd_cnt_d = '0;
      error_d  = 1'b0;
    end else if (o_pipe_enable) begin
      if (i_stall) begin
        if ((32'(wd_cnt_q) + 32'd1) >= 32'(STALL_LIMIT)) begin
          wd_trip  = 1'b1;
          error_d  = 1'b1;
          wd_cnt_d = '0;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end else begin
        wd_cnt_d = '0;
      end
    end
  end

  // Watchdog registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wd_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      error_q  <= error_d;
    end
  end

  assign o_error = error_q;
`else
  logic unused_stall_limit;

  // The limit only matters with the watchdog built in
  assign unused_stall_limit = ^32'(STALL_LIMIT);
  assign wd_trip            = 1'b0;
  assign o_error            = 1'b0;
`endif

endmodule
